uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver, the companion to the team's UART transmitter. Frame format: 1 start bit (0), 8 data bits LSB first, no parity, 1 stop bit (1). Line idles high.
- Synchronises the asynchronous serial line and validates the start bit mid-bit.
- Samples each subsequent bit at mid-bit, presents the received byte with a one-cycle valid strobe, and flags framing errors.
- Sits between the board RX pin and the byte-level consumer (loopback partner of the TX in the UART testbench).

Parameters:
- CLOCKS_PER_BIT, 217, clk cycles per serial bit. Legal range is 4..65535. Clock-count width is sized to hold CLOCKS_PER_BIT-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_RX_Serial  input  1  asynchronous serial line, idle high
- o_RX_Byte  output  8  last correctly framed byte; held until the next good frame
- o_RX_Data_Valid  output  1  one-cycle pulse; o_RX_Byte is new on that cycle
- o_RX_Active  output  1  high while a frame is being received
- o_Frame_Err  output  1  one-cycle pulse; stop bit sampled low
- o_Parity_Err  output  1  one-cycle pulse; parity mismatch (tied 0 when the feature is off)

Behaviour:
- Reset (async assert, sync release): state=IDLE; both synchroniser flops=1; counters=0; o_RX_Byte=0x00; all other outputs=0. Reset mid-frame abandons the frame with no pulses.
- 2-flop synchroniser on i_RX_Serial. The FSM uses only the second flop (rx_s).
- Definitions: H=(CLOCKS_PER_BIT-1)/2 (integer). t0 = the clk edge at which the first flop captures a low.
- IDLE:
  - counter=0, bit index=0.
  - rx_s==0 -> START (entered at edge t0+2).
- START:
  - counter increments each cycle.
  - At counter==H, sample rx_s. If 0: counter=0, go to DATA, o_RX_Active=1. If 1: glitch, return to IDLE with no pulse and o_RX_Active stays 0.
- DATA:
  - At counter==CLOCKS_PER_BIT-1: sample rx_s into shift register bit[index], counter=0.
  - index<7: index+1. index==7: index=0, go to STOP.
  - Bit k is sampled at edge t0+3+H+(k+1)*CLOCKS_PER_BIT.
- STOP:
  - At counter==CLOCKS_PER_BIT-1, sample rx_s.
  - If 1: o_RX_Byte<=shift register, o_RX_Data_Valid=1 for 1 cycle.
  - If 0: o_Frame_Err=1 for 1 cycle, o_RX_Byte unchanged.
  - Either way go to CLEANUP and o_RX_Active=0.
- CLEANUP: exactly one cycle, pulses deassert, then go to IDLE.
- Latency: the valid/error pulse is high in the cycle after edge t0+3+H+9*CLOCKS_PER_BIT. For CLOCKS_PER_BIT=217 this is edge t0+2064.
- Resynchronisation: the FSM returns to IDLE mid-stop-bit, so a start edge arriving right after the stop bit midpoint is caught. Back-to-back frames are received with no gap required.
- Line held low (break): every frame produces o_Frame_Err. After CLEANUP, IDLE sees rx_s==0 and immediately starts a new frame. No lock-up.
- o_RX_Data_Valid and o_Frame_Err are never high in the same cycle. No ready/backpressure exists: the consumer must take the byte on the valid pulse.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP. The even-parity bit is sampled at counter==CLOCKS_PER_BIT-1, and pulse latency grows by CLOCKS_PER_BIT.
  - A mismatch asserts o_Parity_Err for one cycle in CLEANUP (independent of o_Frame_Err).
  - o_RX_Data_Valid pulses and o_RX_Byte updates only if parity matches AND the stop bit is 1.
- When undefined: no PARITY state, frame as above, o_Parity_Err constant 0.

Test Plan:
- CLOCKS_PER_BIT=217, send 0xA5 well-formed -> o_RX_Data_Valid single pulse at t0+2064, o_RX_Byte=0xA5, o_Frame_Err=0, o_RX_Active high from START validation until STOP sample.
- Send 0x00 then 0xFF back-to-back (new start bit immediately after stop bit) -> two valid pulses 2170 cycles apart; bytes 0x00 then 0xFF.
- Drive the line low for 50 cycles, then high -> FSM returns to IDLE; no pulses; o_RX_Active stays 0; o_RX_Byte unchanged.
- Send 0x3C with stop bit forced 0 -> o_Frame_Err pulse at t0+2064, no valid pulse, o_RX_Byte retains the previous value.
- Assert rst_n low during data bit 4 of a frame, release, send 0x81 -> all outputs 0 / o_RX_Byte=0x00 during reset; next frame received as 0x81.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong, even requires 1) -> o_Parity_Err pulse, no valid pulse. With the correct parity bit 1 -> valid pulse with 0x07 at t0+2281.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchroniser and mid-bit sampling.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_RX_Serial,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Data_Valid,
    output logic       o_RX_Active,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLOCKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_active;
    logic          r_ferr;
    logic          w_rx;
    logic          w_tick;

    assign w_rx   = r_sync2;
    assign w_tick = (r_cnt == LAST);

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_RX_Serial;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_perr;
`endif

    // Frame sequencer: start check at half-bit, then one sample per bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_active <= 1'b0;
            r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!w_rx) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_state  <= S_DATA;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx;
                        if (r_idx == 3'd7) begin
                            r_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                // Even parity: data ones plus parity bit must be even.
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_par_bad <= (^r_shift) ^ w_rx;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_cnt    <= '0;
                        r_active <= 1'b0;
                        r_state  <= S_CLEANUP;
                        r_ferr   <= ~w_rx;
`ifdef UART_RX_PARITY_EN
                        r_perr   <= r_par_bad;
                        if (w_rx && !r_par_bad) begin
                            r_byte  <= r_shift;
                            r_valid <= 1'b1;
                        end
`else
                        if (w_rx) begin
                            r_byte  <= r_shift;
                            r_valid <= 1'b1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CLEANUP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_RX_Byte       = r_byte;
    assign o_RX_Data_Valid = r_valid;
    assign o_RX_Active     = r_active;
    assign o_Frame_Err     = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err    = r_perr;
`else
    assign o_Parity_Err    = 1'b0;
`endif

endmodule
